// File: rtl/rv_iopmp_pkg.sv
// ----------------------------------------------------------------------------
// rv_iopmp_pkg
// Shared types for the IOPMP per-transaction sequencer.
//   access_t        : transaction access type (read / write / execute)
//   seq_state_e     : sequencer FSM states (IDLE, SCAN, RESP)
//   seq_rsp_t       : captured decision (allow, err, err_type, err_index)
//   ERR_TYPE_NO_HIT : error type the datapath reports when no entry matched
// ----------------------------------------------------------------------------
package rv_iopmp_pkg;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2,
        ACC_EXEC  = 2'd3
    } access_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic        allow;
        logic        err;
        logic [2:0]  err_type;
        logic [15:0] err_index;
    } seq_rsp_t;

    localparam logic [2:0] ERR_TYPE_NO_HIT = 3'h5;

endpackage

// File: rtl/rv_iopmp_seq_window_ctr.sv
// ----------------------------------------------------------------------------
// rv_iopmp_seq_window_ctr
// Counts which window of NUMBER_INSTANCES entries the datapath is looking at
// and turns that count into the window's base entry index.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : restart at window 0 (takes priority over inc_i)
//   inc_i         : advance to the next window
//   last_o        : current window is the final one (NUM_WINDOWS-1)
//   offset_o      : window count * NUMBER_INSTANCES, zero-extended to 9 bits
// ----------------------------------------------------------------------------
module rv_iopmp_seq_window_ctr #(
    parameter int unsigned NUMBER_INSTANCES = 8,
    parameter int unsigned NUM_WINDOWS      = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic       last_o,
    output logic [8:0] offset_o
);

    // A single window still needs a one-bit counter so the port widths stay legal.
    localparam int unsigned CNT_W = (NUM_WINDOWS > 1) ? $clog2(NUM_WINDOWS) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       w_offset_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (inc_i) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign last_o = (r_cnt == CNT_W'(NUM_WINDOWS - 1));

    // Entry count is capped at 512, so the product always fits in 9 bits;
    // one spare bit keeps the multiply free of truncation warnings.
    assign w_offset_full = 10'(r_cnt) * 10'(NUMBER_INSTANCES);
    assign offset_o      = w_offset_full[8:0];

endmodule

// File: rtl/rv_iopmp_dl_sequencer.sv
// ----------------------------------------------------------------------------
// rv_iopmp_dl_sequencer
// Time-multiplexes the IOPMP matching/decision datapath over all entries.
// A request is latched, windows of NUMBER_INSTANCES entries are stepped from
// offset 0 upward, and the first window that yields a decision produces the
// allow/error response returned over a valid/ready handshake.
//
// Ports:
//   clk_i, rst_ni               : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o   : request handshake (ready only in IDLE)
//   req_sid_i/addr_i/access_i   : request fields, latched on acceptance
//   dp_sid_o/addr_o/access_o    : latched request driven to the datapath
//   dp_entry_offset_o           : base entry index of the current window
//   dp_allow_i/err_i/err_type_i/err_index_i : datapath result for the window
//   rsp_valid_o / rsp_ready_i   : response handshake (valid only in RESP)
//   rsp_allow_o/err_o/err_type_o/err_index_o : captured decision
//   busy_o                      : a transaction is in flight
//
// Configuration macro: RV_IOPMP_SEQ_CONST_LATENCY_EN
//   Defined   : every scan walks all windows; the first decisive window's
//               result is kept, so response latency never reveals which
//               entry matched.
//   Undefined : scan stops at the first decisive window.
// ----------------------------------------------------------------------------
module rv_iopmp_dl_sequencer
    import rv_iopmp_pkg::*;
#(
    parameter int unsigned SID_WIDTH        = 8,
    parameter int unsigned ADDR_WIDTH       = 64,
    parameter int unsigned NUMBER_ENTRIES   = 32,
    parameter int unsigned NUMBER_INSTANCES = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [SID_WIDTH-1:0]  req_sid_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  access_t               req_access_i,
    output logic [SID_WIDTH-1:0]  dp_sid_o,
    output logic [ADDR_WIDTH-1:0] dp_addr_o,
    output access_t               dp_access_o,
    output logic [8:0]            dp_entry_offset_o,
    input  logic                  dp_allow_i,
    input  logic                  dp_err_i,
    input  logic [2:0]            dp_err_type_i,
    input  logic [15:0]           dp_err_index_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_allow_o,
    output logic                  rsp_err_o,
    output logic [2:0]            rsp_err_type_o,
    output logic [15:0]           rsp_err_index_o,
    output logic                  busy_o
);

    localparam int unsigned NUM_WINDOWS = NUMBER_ENTRIES / NUMBER_INSTANCES;

    seq_state_e            r_state;
    logic [SID_WIDTH-1:0]  r_sid;
    logic [ADDR_WIDTH-1:0] r_addr;
    access_t               r_access;
    seq_rsp_t              r_rsp;
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
    logic                  r_decided;
`endif

    logic     w_accept;
    logic     w_scan;
    logic     w_decisive;
    logic     w_last;
    logic     w_ctr_inc;
    seq_rsp_t w_cur_rsp;

    assign w_accept   = (r_state == IDLE) && req_valid_i;
    assign w_scan     = (r_state == SCAN);
    assign w_decisive = dp_err_i | dp_allow_i;

`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
    assign w_ctr_inc = w_scan && !w_last;
`else
    assign w_ctr_inc = w_scan && !w_decisive && !w_last;
`endif

    rv_iopmp_seq_window_ctr #(
        .NUMBER_INSTANCES (NUMBER_INSTANCES),
        .NUM_WINDOWS      (NUM_WINDOWS)
    ) u_window_ctr (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (w_accept),
        .inc_i    (w_ctr_inc),
        .last_o   (w_last),
        .offset_o (dp_entry_offset_o)
    );

    // Decision offered by the current window. Error wins over allow; a window
    // with neither yields the all-zero "no decision" value, which is exactly
    // what is reported when the last window is reached with the datapath off.
    always_comb begin
        w_cur_rsp = '0;
        if (dp_err_i) begin
            w_cur_rsp.err       = 1'b1;
            w_cur_rsp.err_type  = dp_err_type_i;
            w_cur_rsp.err_index = dp_err_index_i;
        end else if (dp_allow_i) begin
            w_cur_rsp.allow = 1'b1;
        end
    end

    // Request latch, decision capture and the IDLE -> SCAN -> RESP sequence.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_sid    <= '0;
            r_addr   <= '0;
            r_access <= ACC_NONE;
            r_rsp    <= '0;
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
            r_decided <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_sid    <= req_sid_i;
                        r_addr   <= req_addr_i;
                        r_access <= req_access_i;
                        r_state  <= SCAN;
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
                        r_decided <= 1'b0;
`endif
                    end
                end
                SCAN: begin
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
                    // Keep loading until something decisive lands; after that
                    // later windows may not disturb the captured decision.
                    if (!r_decided) begin
                        r_rsp <= w_cur_rsp;
                    end
                    if (w_decisive) begin
                        r_decided <= 1'b1;
                    end
                    if (w_last) begin
                        r_state <= RESP;
                    end
`else
                    if (w_decisive || w_last) begin
                        r_rsp   <= w_cur_rsp;
                        r_state <= RESP;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o     = (r_state == IDLE);
    assign busy_o          = (r_state != IDLE);
    assign rsp_valid_o     = (r_state == RESP);
    assign dp_sid_o        = r_sid;
    assign dp_addr_o       = r_addr;
    assign dp_access_o     = r_access;
    assign rsp_allow_o     = r_rsp.allow;
    assign rsp_err_o       = r_rsp.err;
    assign rsp_err_type_o  = r_rsp.err_type;
    assign rsp_err_index_o = r_rsp.err_index;

endmodule

// File: tb/tb_rv_iopmp_dl_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rv_iopmp_dl_sequencer
// Self-checking bench for rv_iopmp_dl_sequencer (32 entries, 8 per window).
// A behavioural datapath answers each window from a per-entry hit table, and
// the expected response/latency is derived from the same table by finding the
// lowest matching entry. Honours RV_IOPMP_SEQ_CONST_LATENCY_EN.
// ----------------------------------------------------------------------------
module tb_rv_iopmp_dl_sequencer;
    import rv_iopmp_pkg::*;

    localparam int NE = 32;
    localparam int NI = 8;
    localparam int NW = NE / NI;

    logic        clk_i  = 1'b0;
    logic        rst_ni = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [7:0]  req_sid_i = '0;
    logic [63:0] req_addr_i = '0;
    access_t     req_access_i = ACC_NONE;
    logic [7:0]  dp_sid_o;
    logic [63:0] dp_addr_o;
    access_t     dp_access_o;
    logic [8:0]  dp_entry_offset_o;
    logic        dp_allow_i;
    logic        dp_err_i;
    logic [2:0]  dp_err_type_i;
    logic [15:0] dp_err_index_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic        rsp_allow_o;
    logic        rsp_err_o;
    logic [2:0]  rsp_err_type_o;
    logic [15:0] rsp_err_index_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    bit entryHit   [NE];
    bit entryAllow [NE];
    bit dpDisabled = 1'b0;
    bit noisyAllow = 1'b0;

    rv_iopmp_dl_sequencer #(
        .SID_WIDTH        (8),
        .ADDR_WIDTH       (64),
        .NUMBER_ENTRIES   (NE),
        .NUMBER_INSTANCES (NI)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_sid_i         (req_sid_i),
        .req_addr_i        (req_addr_i),
        .req_access_i      (req_access_i),
        .dp_sid_o          (dp_sid_o),
        .dp_addr_o         (dp_addr_o),
        .dp_access_o       (dp_access_o),
        .dp_entry_offset_o (dp_entry_offset_o),
        .dp_allow_i        (dp_allow_i),
        .dp_err_i          (dp_err_i),
        .dp_err_type_i     (dp_err_type_i),
        .dp_err_index_i    (dp_err_index_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_allow_o       (rsp_allow_o),
        .rsp_err_o         (rsp_err_o),
        .rsp_err_type_o    (rsp_err_type_o),
        .rsp_err_index_o   (rsp_err_index_o),
        .busy_o            (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural datapath: lowest hit inside the presented window decides.
    // A denied hit reports the access type as error type and may also raise
    // allow (noisyAllow) to probe error dominance. The last window reports
    // no-hit error 5 unless the datapath is disabled.
    always_comb begin
        int   base;
        logic found;
        base           = int'(dp_entry_offset_o);
        found          = 1'b0;
        dp_allow_i     = 1'b0;
        dp_err_i       = 1'b0;
        dp_err_type_i  = 3'd0;
        dp_err_index_i = 16'd0;
        for (int k = 0; k < NI; k++) begin
            if (!found && (base + k) < NE && entryHit[base + k]) begin
                found = 1'b1;
                if (entryAllow[base + k]) begin
                    dp_allow_i = 1'b1;
                end else begin
                    dp_err_i       = 1'b1;
                    dp_err_type_i  = {1'b0, dp_access_o};
                    dp_err_index_i = 16'(base + k);
                    dp_allow_i     = noisyAllow;
                end
            end
        end
        if (!found && base == (NW - 1) * NI && !dpDisabled) begin
            dp_err_i      = 1'b1;
            dp_err_type_i = 3'h5;
        end
    end

    // Expected decision and latency straight from the hit table.
    function automatic void predict(input access_t acc, output seq_rsp_t rsp, output int lat);
        int first;
        first = -1;
        for (int i = 0; i < NE; i++) begin
            if (first < 0 && entryHit[i]) first = i;
        end
        rsp = '0;
        if (first >= 0) begin
            if (entryAllow[first]) begin
                rsp.allow = 1'b1;
            end else begin
                rsp.err       = 1'b1;
                rsp.err_type  = {1'b0, acc};
                rsp.err_index = 16'(first);
            end
        end else if (!dpDisabled) begin
            rsp.err      = 1'b1;
            rsp.err_type = 3'h5;
        end
`ifdef RV_IOPMP_SEQ_CONST_LATENCY_EN
        lat = NW;
`else
        lat = (first >= 0) ? (first / NI + 1) : NW;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearEntries();
        for (int i = 0; i < NE; i++) begin
            entryHit[i]   = 1'b0;
            entryAllow[i] = 1'b0;
        end
        dpDisabled = 1'b0;
        noisyAllow = 1'b0;
    endtask

    task automatic setHit(input int idx, input bit allow);
        entryHit[idx]   = 1'b1;
        entryAllow[idx] = allow;
    endtask

    task automatic checkRsp(input string tag, input seq_rsp_t exp);
        checkOutput({tag, ".allow"}, 64'(rsp_allow_o), 64'(exp.allow));
        checkOutput({tag, ".err"}, 64'(rsp_err_o), 64'(exp.err));
        checkOutput({tag, ".type"}, 64'(rsp_err_type_o), 64'(exp.err_type));
        checkOutput({tag, ".index"}, 64'(rsp_err_index_o), 64'(exp.err_index));
    endtask

    // Called at the negedge after acceptance; walks windows checking offsets
    // until a response appears or the cycle budget runs out.
    task automatic waitResponse(output int cycles);
        cycles = 0;
        while (!rsp_valid_o && cycles < NW + 4) begin
            checkOutput("offset", 64'(dp_entry_offset_o), 64'(cycles * NI));
            checkOutput("scan.reqReady", 64'(req_ready_o), 64'd0);
            @(negedge clk_i);
            cycles++;
        end
        checkOutput("rspValid", 64'(rsp_valid_o), 64'd1);
    endtask

    task automatic releaseResponse();
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        checkOutput("release.rspValid", 64'(rsp_valid_o), 64'd0);
        checkOutput("release.reqReady", 64'(req_ready_o), 64'd1);
        checkOutput("release.busy", 64'(busy_o), 64'd0);
    endtask

    // One full transaction starting from an idle negedge.
    task automatic applyStimulus(input logic [7:0] sid, input logic [63:0] addr, input access_t acc,
                                 input int hold, input bit earlyReady);
        seq_rsp_t exp;
        int       lat;
        int       cycles;
        predict(acc, exp, lat);
        req_sid_i    = sid;
        req_addr_i   = addr;
        req_access_i = acc;
        req_valid_i  = 1'b1;
        rsp_ready_i  = earlyReady;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        checkOutput("dp.sid", 64'(dp_sid_o), 64'(sid));
        checkOutput("dp.addr", dp_addr_o, addr);
        checkOutput("dp.access", 64'(dp_access_o), 64'(acc));
        checkOutput("busy", 64'(busy_o), 64'd1);
        waitResponse(cycles);
        checkOutput("latency", 64'(cycles), 64'(lat));
        checkRsp("rsp", exp);
        if (earlyReady) begin
            @(negedge clk_i);
            rsp_ready_i = 1'b0;
            checkOutput("early.rspValid", 64'(rsp_valid_o), 64'd0);
            checkOutput("early.reqReady", 64'(req_ready_o), 64'd1);
        end else begin
            repeat (hold) begin
                @(negedge clk_i);
                checkOutput("hold.rspValid", 64'(rsp_valid_o), 64'd1);
                checkOutput("hold.reqReady", 64'(req_ready_o), 64'd0);
                checkRsp("hold", exp);
            end
            releaseResponse();
        end
    endtask

    initial begin
        seq_rsp_t exp;
        int       lat;
        int       cycles;

        $display("[TB] start, windows=%0d", NW);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("reset.reqReady", 64'(req_ready_o), 64'd1);
        checkOutput("reset.busy", 64'(busy_o), 64'd0);
        checkOutput("reset.rspValid", 64'(rsp_valid_o), 64'd0);
        checkOutput("reset.rspFields", 64'({rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o}), 64'd0);
        checkOutput("reset.dp", 64'({dp_sid_o, dp_access_o, dp_entry_offset_o}) | dp_addr_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Allow on entry 2: first window decides.
        clearEntries();
        setHit(2, 1'b1);
        applyStimulus(8'h11, 64'h0000_1000, ACC_READ, 0, 1'b0);

        // Denied read on entry 26: walks to the last window.
        clearEntries();
        setHit(26, 1'b0);
        applyStimulus(8'h22, 64'h0000_2600, ACC_READ, 0, 1'b0);

        // No match: datapath raises no-hit on the last window.
        clearEntries();
        applyStimulus(8'h33, 64'hDEAD_0000, ACC_WRITE, 1, 1'b0);

        // No match with the datapath disabled: neither allow nor error.
        clearEntries();
        dpDisabled = 1'b1;
        applyStimulus(8'h44, 64'h0, ACC_EXEC, 0, 1'b1);

        // Error and allow together: error must win.
        clearEntries();
        setHit(13, 1'b0);
        noisyAllow = 1'b1;
        applyStimulus(8'h55, 64'h5555_5555, ACC_WRITE, 0, 1'b0);

        // Allow on entry 2 followed by a deny on entry 10.
        clearEntries();
        setHit(2, 1'b1);
        setHit(10, 1'b0);
        applyStimulus(8'h66, 64'h6666, ACC_READ, 0, 1'b0);

        // Back-pressure for 5 cycles with a second request queued behind it.
        clearEntries();
        setHit(2, 1'b1);
        predict(ACC_READ, exp, lat);
        req_sid_i = 8'hA1; req_addr_i = 64'hA1; req_access_i = ACC_READ; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        waitResponse(cycles);
        req_sid_i = 8'hB2; req_addr_i = 64'hB2; req_valid_i = 1'b1;
        repeat (5) begin
            @(negedge clk_i);
            checkOutput("bp.reqReady", 64'(req_ready_o), 64'd0);
            checkOutput("bp.dpSid", 64'(dp_sid_o), 64'hA1);
            checkRsp("bp", exp);
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        rsp_ready_i = 1'b0;
        checkOutput("bp.idleReady", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        checkOutput("bp.queuedBusy", 64'(busy_o), 64'd1);
        checkOutput("bp.queuedSid", 64'(dp_sid_o), 64'hB2);
        waitResponse(cycles);
        checkRsp("bp.queued", exp);
        releaseResponse();

        // Reset during window 2 of a long scan.
        clearEntries();
        req_sid_i = 8'hC3; req_addr_i = 64'hC3C3; req_access_i = ACC_WRITE; req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cycles = 0;
        while (dp_entry_offset_o != 9'd16 && cycles < NW + 4) begin
            @(negedge clk_i);
            cycles++;
        end
        checkOutput("rst.reachedWin2", 64'(dp_entry_offset_o), 64'd16);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("rst.reqReady", 64'(req_ready_o), 64'd1);
        checkOutput("rst.busy", 64'(busy_o), 64'd0);
        checkOutput("rst.rspValid", 64'(rsp_valid_o), 64'd0);
        checkOutput("rst.rspFields", 64'({rsp_allow_o, rsp_err_o, rsp_err_type_o, rsp_err_index_o}), 64'd0);
        checkOutput("rst.dp", 64'({dp_sid_o, dp_access_o, dp_entry_offset_o}) | dp_addr_o, 64'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        setHit(9, 1'b1);
        applyStimulus(8'hD4, 64'hD4D4, ACC_READ, 0, 1'b0);

        // Randomised transactions.
        for (int n = 0; n < 16; n++) begin
            int nh;
            clearEntries();
            nh = int'($urandom_range(0, 2));
            for (int h = 0; h < nh; h++) begin
                setHit(int'($urandom_range(0, NE - 1)), 1'($urandom_range(0, 1)));
            end
            dpDisabled = ($urandom_range(0, 3) == 0);
            noisyAllow = 1'($urandom_range(0, 1));
            applyStimulus(8'($urandom), {$urandom, $urandom}, access_t'($urandom_range(1, 3)),
                          int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
